// File: rtl/query_pourer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : query_pourer_pkg
// Purpose  : Shared parameters for the query pourer and its query buffer:
//            default word/length widths, buffer depth, 2-bit base encodings,
//            the idle value of the q_o push bus and the pour FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package query_pourer_pkg;

    localparam int C_WORD_W       = 32;  // packed query word width (even)
    localparam int C_LEN_BIT      = 10;  // query length counter width
    localparam int C_BUFFER_DEPTH = 64;  // downstream query buffer depth

    // 2-bit base encodings as packed in word_i and pushed on q_o[1:0]
    localparam logic [1:0] C_BASE_A = 2'b00;
    localparam logic [1:0] C_BASE_C = 2'b01;
    localparam logic [1:0] C_BASE_G = 2'b10;
    localparam logic [1:0] C_BASE_T = 2'b11;

    // q_o value on cycles with no push
    localparam logic [2:0] C_Q_NONE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POUR = 2'd1,
        ST_GAP  = 2'd2,
        ST_TERM = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/query_pourer_if.sv
`default_nettype none
// ============================================================================
// Module   : query_pourer_if
// Purpose  : Bundles the pourer's command, word-stream and buffer-side
//            signals.
//            command : start_i, len_i, last_i
//            words   : word_i, word_valid_i, word_ready_o
//            buffer  : full_i, q_o, pouring_o, pouring_last_o
//            status  : busy_o, done_o
//            master = stimulus / upstream side, slave = the pourer.
// Revision : 1.0 - initial release
// ============================================================================
interface query_pourer_if
    import query_pourer_pkg::*;
#(
    parameter int WORD_W  = C_WORD_W,
    parameter int LEN_BIT = C_LEN_BIT
) ();

    logic               start_i;
    logic [LEN_BIT-1:0] len_i;
    logic               last_i;
    logic [WORD_W-1:0]  word_i;
    logic               word_valid_i;
    logic               word_ready_o;
    logic               full_i;
    logic [2:0]         q_o;
    logic               pouring_o;
    logic               pouring_last_o;
    logic               busy_o;
    logic               done_o;

    modport master (
        output start_i, len_i, last_i, word_i, word_valid_i, full_i,
        input  word_ready_o, q_o, pouring_o, pouring_last_o, busy_o, done_o
    );

    modport slave (
        input  start_i, len_i, last_i, word_i, word_valid_i, full_i,
        output word_ready_o, q_o, pouring_o, pouring_last_o, busy_o, done_o
    );

endinterface
`default_nettype wire

// File: rtl/query_pourer.sv
`default_nettype none
// ============================================================================
// Module   : query_pourer
// Purpose  : Unpacks a stream of packed 2-bit-base words and pours len_i
//            bases, one per cycle, into a downstream query buffer, framed
//            by pouring_o / pouring_last_o, followed by a one-cycle gap and,
//            for the last query of a batch, a terminator cycle.
// Ports    : clk, rst_n (async, active-low)
//            bus (query_pourer_if.slave): start/len/last command, word
//            handshake, buffer full flag, q_o push bus, framing and status.
// Revision : 1.0 - initial release
// ============================================================================
module query_pourer
    import query_pourer_pkg::*;
#(
    parameter int WORD_W  = C_WORD_W,   // must be even
    parameter int LEN_BIT = C_LEN_BIT
) (
    input  logic          clk,
    input  logic          rst_n,
    query_pourer_if.slave bus
);

    localparam int C_BPW   = WORD_W / 2;
    localparam int C_IDX_W = (C_BPW > 1) ? $clog2(C_BPW) : 1;

    state_t               state_q,   state_d;
    logic [WORD_W-1:0]    sreg_q,    sreg_d;     // held word, current base in [1:0]
    logic [C_IDX_W-1:0]   bidx_q,    bidx_d;     // index of current base in word
    logic                 have_q,    have_d;     // sreg holds an unsent base
    logic [LEN_BIT-1:0]   rem_q,     rem_d;      // bases still to pour
    logic                 last_q,    last_d;     // latched last_i
    logic                 pouring_q, pouring_d;
    logic                 plast_q,   plast_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;

    logic                 w_emit;
    logic                 w_word_end;
    logic                 w_final;
    logic                 w_ready;
    logic                 w_load;

    // full_i is a registered, current-cycle flag from the buffer, so the push
    // and the refill request are qualified by it directly; everything else
    // feeding q_o and word_ready_o comes straight from flops.
    assign w_emit     = (state_q == ST_POUR) && have_q && !bus.full_i;
    assign w_word_end = (bidx_q == C_IDX_W'(C_BPW - 1));
    assign w_final    = (rem_q == LEN_BIT'(1));
    // Refill when empty, or in the same cycle the held word's last base goes
    // out so the next word lands with no bubble. Never fetch past the end.
    assign w_ready    = (state_q == ST_POUR) &&
                        (!have_q || (w_emit && w_word_end && !w_final));
    assign w_load     = w_ready && bus.word_valid_i;

    assign bus.q_o            = w_emit ? {1'b1, sreg_q[1:0]} : C_Q_NONE;
    assign bus.word_ready_o   = w_ready;
    assign bus.pouring_o      = pouring_q;
    assign bus.pouring_last_o = plast_q;
    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        bidx_d  = bidx_q;
        have_d  = have_q;
        rem_d   = rem_q;
        last_d  = last_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    last_d = bus.last_i;
                    rem_d  = bus.len_i;
                    have_d = 1'b0;
                    bidx_d = '0;
                    if (bus.len_i != '0) begin
                        state_d = ST_POUR;
                    end else if (bus.last_i) begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_POUR: begin
                if (w_emit) begin
                    sreg_d = sreg_q >> 2;
                    bidx_d = bidx_q + C_IDX_W'(1);
                    rem_d  = rem_q - LEN_BIT'(1);
                    // Unused tail bases of the final word are simply dropped.
                    if (w_word_end || w_final) begin
                        have_d = 1'b0;
                    end
                    if (w_final) begin
                        state_d = ST_GAP;
                    end
                end
                if (w_load) begin
                    sreg_d = bus.word_i;
                    bidx_d = '0;
                    have_d = 1'b1;
                end
            end
            ST_GAP: begin
                state_d = last_q ? ST_TERM : ST_IDLE;
            end
            ST_TERM: begin
                // Terminator is accepted on the first non-full cycle.
                if (!bus.full_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The frame opens with the first word so the buffer never sees a
        // frame head with no base behind it; it then stays open through
        // stalls until the final base.
        pouring_d = (state_d == ST_POUR) && (have_d || pouring_q);
        plast_d   = (state_d == ST_TERM) ||
                    (last_d && (pouring_d || (state_d == ST_GAP)));
        busy_d    = (state_d != ST_IDLE);
        // Pulse on the first IDLE cycle after a query, including a
        // zero-length non-final one that never leaves IDLE.
        done_d    = (state_d == ST_IDLE) &&
                    ((state_q != ST_IDLE) || bus.start_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sreg_q    <= '0;
            bidx_q    <= '0;
            have_q    <= 1'b0;
            rem_q     <= '0;
            last_q    <= 1'b0;
            pouring_q <= 1'b0;
            plast_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bidx_q    <= bidx_d;
            have_q    <= have_d;
            rem_q     <= rem_d;
            last_q    <= last_d;
            pouring_q <= pouring_d;
            plast_q   <= plast_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_query_pourer.sv
`default_nettype none
// ============================================================================
// Module   : tb_query_pourer
// Purpose  : Self-checking bench for query_pourer. Expected bases are queued
//            when a query is launched and popped as q_o pushes appear;
//            framing, gap/terminator, done and reset behaviour are counted
//            per query and compared against expected totals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_query_pourer;
    import query_pourer_pkg::*;

    localparam int WW  = 32;
    localparam int LB  = 10;
    localparam int BPW = WW / 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    query_pourer_if #(.WORD_W(WW), .LEN_BIT(LB)) bus ();

    query_pourer #(.WORD_W(WW), .LEN_BIT(LB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [1:0]    sbq[$];   // expected bases in pour order
    logic [WW-1:0] wq[$];    // words offered on the word handshake

    int relc, flo, fhi, restart_at, exp_len;
    int n_val, n_pour, n_tail, n_tail_pl, n_tail_full, n_done, n_busy, n_plast;
    int first_v, last_v;
    bit seen_val;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        bus.start_i      = (relc == restart_at);
        bus.len_i        = LB'(5);
        bus.last_i       = 1'b0;
        bus.full_i       = (relc >= flo) && (relc <= fhi);
        bus.word_valid_i = (wq.size() != 0);
        bus.word_i       = (wq.size() != 0) ? wq[0] : '0;
    endtask

    // Observe one cycle at the falling edge, then advance to just after the
    // next rising edge and drive the following cycle's inputs.
    task automatic tick();
        logic xfer;
        @(negedge clk);
        if (bus.full_i) check_eq("no_valid_when_full", 32'(bus.q_o[2]), 0);
        if (bus.q_o[2]) begin
            if (sbq.size() == 0) check_eq("extra_base", 32'(bus.q_o), 0);
            else                 check_eq("base", 32'(bus.q_o[1:0]), 32'(sbq.pop_front()));
            if (!seen_val) first_v = relc;
            last_v   = relc;
            seen_val = 1'b1;
            n_val++;
        end
        if (bus.pouring_o)      n_pour++;
        if (bus.pouring_last_o) n_plast++;
        if (bus.busy_o)         n_busy++;
        if (bus.done_o)         n_done++;
        if (bus.busy_o && !bus.pouring_o && (seen_val || exp_len == 0)) begin
            n_tail++;
            if (bus.pouring_last_o) n_tail_pl++;
            if (bus.full_i)         n_tail_full++;
        end
        xfer = bus.word_valid_i && bus.word_ready_o;
        @(posedge clk);
        #1;
        if (xfer) void'(wq.pop_front());
        relc++;
        drive_inputs();
    endtask

    task automatic launch(input int len, input bit last, input bit fixed,
                          input int f_lo, input int f_hi,
                          input int rs_at, input int rst_at);
        int            cnt;
        logic [WW-1:0] w;
        n_val = 0; n_pour = 0; n_tail = 0; n_tail_pl = 0; n_tail_full = 0;
        n_done = 0; n_busy = 0; n_plast = 0;
        first_v = -1; last_v = -1; seen_val = 1'b0; exp_len = len;
        flo = f_lo; fhi = f_hi; restart_at = rs_at;
        cnt = 0;
        while (cnt < len) begin
            w = fixed ? WW'(32'h0000_01E4) : WW'($urandom);
            wq.push_back(w);
            for (int k = 0; k < BPW && cnt < len; k++) begin
                sbq.push_back(w[2*k +: 2]);
                cnt++;
            end
        end
        wq.push_back(WW'(32'hDEAD_BEEF));   // must never be fetched
        relc = 0;
        drive_inputs();
        bus.start_i = 1'b1;
        bus.len_i   = LB'(len);
        bus.last_i  = last;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (relc == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_q",           32'(bus.q_o),            0);
                check_eq("rst_pouring",     32'(bus.pouring_o),      0);
                check_eq("rst_pouring_last",32'(bus.pouring_last_o), 0);
                check_eq("rst_busy",        32'(bus.busy_o),         0);
                check_eq("rst_done",        32'(bus.done_o),         0);
                check_eq("rst_ready",       32'(bus.word_ready_o),   0);
                wq.delete();
                sbq.delete();
                flo = 1000; fhi = -1; restart_at = -1;
                drive_inputs();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            if (n_done != 0) break;
        end
        tick();
        tick();
        check_eq("sb_empty",          32'(sbq.size()), 0);
        check_eq("no_fetch_past_end", 32'(wq.size()),  1);
        check_eq("done_once",         32'(n_done),     1);
        wq.delete();
        drive_inputs();
    endtask

    initial begin
        int rlen;
        bit rlast;
        rst_n = 1'b0;
        relc = 0; flo = 1000; fhi = -1; restart_at = -1; exp_len = 0;
        drive_inputs();
        @(negedge clk);
        check_eq("reset_q",            32'(bus.q_o),            0);
        check_eq("reset_pouring",      32'(bus.pouring_o),      0);
        check_eq("reset_pouring_last", 32'(bus.pouring_last_o), 0);
        check_eq("reset_busy",         32'(bus.busy_o),         0);
        check_eq("reset_done",         32'(bus.done_o),         0);
        check_eq("reset_ready",        32'(bus.word_ready_o),   0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Short query from one fixed word: bases 0,1,2,3,1, no terminator
        launch(5, 1'b0, 1'b1, 1000, -1, -1, -1);
        check_eq("t1_nval",    32'(n_val),     5);
        check_eq("t1_first",   32'(first_v),   2);
        check_eq("t1_last",    32'(last_v),    6);
        check_eq("t1_pour",    32'(n_pour),    5);
        check_eq("t1_tail",    32'(n_tail),    1);
        check_eq("t1_tail_pl", 32'(n_tail_pl), 0);

        // Two words, final query: no bubble at the word boundary, GAP + TERM
        launch(20, 1'b1, 1'b0, 1000, -1, -1, -1);
        check_eq("t2_nval",    32'(n_val),            20);
        check_eq("t2_contig",  32'(last_v - first_v), 19);
        check_eq("t2_pour",    32'(n_pour),           20);
        check_eq("t2_tail",    32'(n_tail),           2);
        check_eq("t2_tail_pl", 32'(n_tail_pl),        2);

        // Buffer full for three cycles mid-pour
        launch(20, 1'b0, 1'b0, 8, 10, -1, -1);
        check_eq("t3_nval",    32'(n_val),  20);
        check_eq("t3_last",    32'(last_v), 24);
        check_eq("t3_pour",    32'(n_pour), 23);
        check_eq("t3_tail",    32'(n_tail), 1);

        // Empty final query, terminator blocked 4 cycles, restart while busy
        launch(0, 1'b1, 1'b0, 2, 5, 3, -1);
        check_eq("t4_nval",      32'(n_val),       0);
        check_eq("t4_pour",      32'(n_pour),      0);
        check_eq("t4_tail",      32'(n_tail),      6);
        check_eq("t4_tail_pl",   32'(n_tail_pl),   6);
        check_eq("t4_tail_full", 32'(n_tail_full), 4);

        // Empty non-final query: done next cycle, never busy
        launch(0, 1'b0, 1'b0, 1000, -1, -1, -1);
        check_eq("t5_busy",  32'(n_busy),  0);
        check_eq("t5_plast", 32'(n_plast), 0);

        // Random lengths at full rate
        for (int i = 0; i < 4; i++) begin
            rlen  = int'($urandom_range(1, 40));
            rlast = 1'($urandom_range(0, 1));
            launch(rlen, rlast, 1'b0, 1000, -1, -1, -1);
            check_eq("rnd_nval",    32'(n_val),              32'(rlen));
            check_eq("rnd_first",   32'(first_v),            2);
            check_eq("rnd_contig",  32'(last_v - first_v),   32'(rlen - 1));
            check_eq("rnd_tail",    32'(n_tail),             32'(1 + int'(rlast)));
            check_eq("rnd_tail_pl", 32'(n_tail_pl),          32'(2 * int'(rlast)));
        end

        // Reset after three bases of a final query: abandoned, no terminator
        launch(20, 1'b1, 1'b0, 1000, -1, -1, 5);
        check_eq("t7_nval_before_rst", 32'(n_val), 3);
        n_busy = 0; n_plast = 0; n_val = 0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("t7_busy_after",  32'(n_busy),  0);
        check_eq("t7_plast_after", 32'(n_plast), 0);
        check_eq("t7_nval_after",  32'(n_val),   0);

        // Normal query after the reset
        launch(7, 1'b1, 1'b0, 1000, -1, -1, -1);
        check_eq("t8_nval",    32'(n_val),   7);
        check_eq("t8_first",   32'(first_v), 2);
        check_eq("t8_tail_pl", 32'(n_tail_pl), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
